enable_debouncer: RTL and testbench

Input conditioner that sits directly upstream of the free-running LED counter and drives its `enable` input. It synchronises a raw, bouncing push-button and debounces it with a qualification counter. Each qualified press toggles a registered run/stop level (`enable`) and emits a one-cycle `press_pulse`. The counter can therefore be started and stopped from a single board button.

---
 rtl/dbnc_pkg.sv | 14 +
 rtl/sync_2ff.sv | 24 ++
 rtl/enable_debouncer.sv | 88 ++++++++
 tb/tb_enable_debouncer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dbnc_pkg.sv
// rtl/dbnc_pkg.sv - shared state encoding and defaults for the button debouncer
package dbnc_pkg;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } dbnc_state_t;

  // Board clock default: about 10 ms of stable level at 100 MHz.
  localparam int unsigned DEFAULT_STABLE_CYCLES = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchroniser with synchronous reset to 0
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/enable_debouncer.sv
// rtl/enable_debouncer.sv - debounced push-button that toggles a run/stop enable level
module enable_debouncer
  import dbnc_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_W         = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_clean,
  output logic press_pulse,
  output logic enable
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s2;
  dbnc_state_t      state;
  logic [CNT_W-1:0] cnt;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (btn_raw),
    .q     (s2)
  );

  // cnt holds the number of consecutive matching samples already seen, so the
  // N-th sample is the one that arrives while cnt equals N-1.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= LOW;
      cnt         <= '0;
      btn_clean   <= 1'b0;
      press_pulse <= 1'b0;
      enable      <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      case (state)
        LOW: begin
          if (s2) begin
            state <= WAIT_HI;
            cnt   <= CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!s2) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= HIGH;
            cnt         <= '0;
            btn_clean   <= 1'b1;
            press_pulse <= 1'b1;
            enable      <= ~enable;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!s2) begin
            state <= WAIT_LO;
            cnt   <= CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (s2) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= LOW;
            cnt       <= '0;
            btn_clean <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enable_debouncer.sv
// tb/tb_enable_debouncer.sv - directed self-checking bench for enable_debouncer with N=4
module tb_enable_debouncer;

  logic clock = 1'b0;
  logic reset;
  logic btn_raw;
  logic btn_clean;
  logic press_pulse;
  logic enable;

  int compared   = 0;
  int mismatched = 0;
  int pulse_count = 0;

  enable_debouncer #(
    .STABLE_CYCLES (4),
    .CNT_W         (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_clean   (btn_clean),
    .press_pulse (press_pulse),
    .enable      (enable)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (press_pulse === 1'b1) pulse_count++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    btn_raw = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      compared++;
      if ({btn_clean, press_pulse, enable} !== 3'b000) begin
        $display("FAIL reset_hold cycle %0d: got %b expected 000", i, {btn_clean, press_pulse, enable});
        mismatched++;
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      compared++;
      if ({btn_clean, press_pulse, enable} !== 3'b000) begin
        $display("FAIL reset_after cycle %0d: got %b expected 000", i, {btn_clean, press_pulse, enable});
        mismatched++;
      end
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] exp;
    btn_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp = {(i >= 6), (i == 6), (i >= 6)};
      compared++;
      if ({btn_clean, press_pulse, enable} !== exp) begin
        $display("FAIL clean_press cycle %0d: got %b expected %b", i, {btn_clean, press_pulse, enable}, exp);
        mismatched++;
      end
    end
  endtask

  task automatic test_release_second_press();
    logic [2:0] exp;
    btn_raw = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp = {(i < 6), 1'b0, 1'b1};
      compared++;
      if ({btn_clean, press_pulse, enable} !== exp) begin
        $display("FAIL release cycle %0d: got %b expected %b", i, {btn_clean, press_pulse, enable}, exp);
        mismatched++;
      end
    end
    btn_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp = {(i >= 6), (i == 6), (i < 6)};
      compared++;
      if ({btn_clean, press_pulse, enable} !== exp) begin
        $display("FAIL second_press cycle %0d: got %b expected %b", i, {btn_clean, press_pulse, enable}, exp);
        mismatched++;
      end
    end
    btn_raw = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    compared++;
    if ({btn_clean, press_pulse, enable} !== 3'b000) begin
      $display("FAIL second_release: got %b expected 000", {btn_clean, press_pulse, enable});
      mismatched++;
    end
  endtask

  task automatic test_glitch();
    btn_raw = 1'b1;
    for (int i = 1; i <= 3; i++) step();
    btn_raw = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      compared++;
      if ({btn_clean, press_pulse, enable} !== 3'b000) begin
        $display("FAIL glitch cycle %0d: got %b expected 000", i, {btn_clean, press_pulse, enable});
        mismatched++;
      end
    end
  endtask

  task automatic test_bounce();
    logic [2:0] exp;
    logic [3:0] pattern;
    pattern = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      btn_raw = pattern[3-i];
      step();
    end
    btn_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp = {(i >= 6), (i == 6), (i >= 6)};
      compared++;
      if ({btn_clean, press_pulse, enable} !== exp) begin
        $display("FAIL bounce cycle %0d: got %b expected %b", i, {btn_clean, press_pulse, enable}, exp);
        mismatched++;
      end
    end
    btn_raw = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp = {(i < 6), 1'b0, 1'b1};
      compared++;
      if ({btn_clean, press_pulse, enable} !== exp) begin
        $display("FAIL bounce_release cycle %0d: got %b expected %b", i, {btn_clean, press_pulse, enable}, exp);
        mismatched++;
      end
    end
  endtask

  task automatic test_reset_mid_operation();
    logic [2:0] exp;
    btn_raw = 1'b1;
    for (int i = 1; i <= 4; i++) step();
    reset = 1'b1;
    step();
    compared++;
    if ({btn_clean, press_pulse, enable} !== 3'b000) begin
      $display("FAIL mid_reset: got %b expected 000", {btn_clean, press_pulse, enable});
      mismatched++;
    end
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp = {(i >= 6), (i == 6), (i >= 6)};
      compared++;
      if ({btn_clean, press_pulse, enable} !== exp) begin
        $display("FAIL held_after_reset cycle %0d: got %b expected %b", i, {btn_clean, press_pulse, enable}, exp);
        mismatched++;
      end
    end
    btn_raw = 1'b0;
    for (int i = 1; i <= 8; i++) step();
    compared++;
    if ({btn_clean, press_pulse, enable} !== 3'b001) begin
      $display("FAIL mid_reset_release: got %b expected 001", {btn_clean, press_pulse, enable});
      mismatched++;
    end
  endtask

  // Exactly N cycles of high input is the shortest press that must be accepted.
  task automatic test_min_width();
    logic [2:0] exp;
    btn_raw = 1'b1;
    for (int i = 1; i <= 4; i++) step();
    btn_raw = 1'b0;
    for (int i = 5; i <= 16; i++) begin
      step();
      exp = {(i >= 6 && i <= 9), (i == 6), (i < 6)};
      compared++;
      if ({btn_clean, press_pulse, enable} !== exp) begin
        $display("FAIL min_width cycle %0d: got %b expected %b", i, {btn_clean, press_pulse, enable}, exp);
        mismatched++;
      end
    end
  endtask

  task automatic test_pulse_total();
    compared++;
    if (pulse_count !== 5) begin
      $display("FAIL pulse_total: got %0d expected 5", pulse_count);
      mismatched++;
    end
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 1'b0;
    test_reset();
    test_clean_press();
    test_release_second_press();
    test_glitch();
    test_bounce();
    test_reset_mid_operation();
    test_min_width();
    test_pulse_total();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
